// File: rtl/mem_stage.sv
// Memory-access stage: request/ack data-memory port with byte-lane steering and load extension.
// Define MEM_ALIGN_EXC_EN to flag misaligned halfword/word accesses instead of performing them.
module mem_stage (
  input  logic        CLK,
  input  logic        RST,
  input  logic        InValid,
  input  logic [31:0] Ins,
  input  logic [31:0] Result,
  input  logic [31:0] Rdata2,
  output logic        Stall,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [3:0]  MemBe,
  output logic [31:0] MemWdata,
  input  logic        MemAck,
  input  logic [31:0] MemRdata,
  output logic        Valid,
  output logic [31:0] Wdata,
  output logic        Exc
);

  localparam logic [5:0] OpLb  = 6'h20;
  localparam logic [5:0] OpLh  = 6'h21;
  localparam logic [5:0] OpLw  = 6'h23;
  localparam logic [5:0] OpLbu = 6'h24;
  localparam logic [5:0] OpLhu = 6'h25;
  localparam logic [5:0] OpSb  = 6'h28;
  localparam logic [5:0] OpSh  = 6'h29;
  localparam logic [5:0] OpSw  = 6'h2B;

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [1:0]  off_q, off_d;
  logic        memreq_q, memreq_d;
  logic        memwe_q, memwe_d;
  logic [31:0] memaddr_q, memaddr_d;
  logic [3:0]  membe_q, membe_d;
  logic [31:0] memwdata_q, memwdata_d;
  logic        valid_q, valid_d;
  logic [31:0] wdata_q, wdata_d;

  logic [5:0]  opcode;
  logic        is_load, is_store, is_memop, misaligned;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic        unused_ins;

  assign opcode     = Ins[31:26];
  assign unused_ins = ^Ins[25:0];

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    case (opcode)
      OpLb, OpLh, OpLw, OpLbu, OpLhu: is_load  = 1'b1;
      OpSb, OpSh, OpSw:               is_store = 1'b1;
      default: ;
    endcase
  end

  assign is_memop = is_load | is_store;

`ifdef MEM_ALIGN_EXC_EN
  assign misaligned = (((opcode == OpLh) || (opcode == OpLhu) || (opcode == OpSh)) && Result[0])
                    | (((opcode == OpLw) || (opcode == OpSw)) && (Result[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Store lanes are computed from the live offset; loads always enable all four lanes.
  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = Rdata2;
    case (opcode)
      OpSb: begin
        lane_be    = 4'b0001 << Result[1:0];
        lane_wdata = {4{Rdata2[7:0]}};
      end
      OpSh: begin
        lane_be    = Result[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{Rdata2[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = MemRdata[7:0];
    case (off_q)
      2'd1:    ld_byte = MemRdata[15:8];
      2'd2:    ld_byte = MemRdata[23:16];
      2'd3:    ld_byte = MemRdata[31:24];
      default: ld_byte = MemRdata[7:0];
    endcase
    ld_half = off_q[1] ? MemRdata[31:16] : MemRdata[15:0];
    case (op_q)
      OpLb:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      OpLbu:   ld_data = {24'd0, ld_byte};
      OpLh:    ld_data = {{16{ld_half[15]}}, ld_half};
      OpLhu:   ld_data = {16'd0, ld_half};
      default: ld_data = MemRdata;
    endcase
  end

`ifdef MEM_ALIGN_EXC_EN
  logic exc_q, exc_d;
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    off_d      = off_q;
    memreq_d   = memreq_q;
    memwe_d    = memwe_q;
    memaddr_d  = memaddr_q;
    membe_d    = membe_q;
    memwdata_d = memwdata_q;
    valid_d    = 1'b0;
    wdata_d    = wdata_q;
`ifdef MEM_ALIGN_EXC_EN
    exc_d      = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (InValid) begin
          if (!is_memop) begin
            valid_d = 1'b1;
            wdata_d = Result;
          end
`ifdef MEM_ALIGN_EXC_EN
          else if (misaligned) begin
            valid_d = 1'b1;
            exc_d   = 1'b1;
            wdata_d = Result;
          end
`endif
          else begin
            op_d       = opcode;
            off_d      = Result[1:0];
            memreq_d   = 1'b1;
            memwe_d    = is_store;
            memaddr_d  = {Result[31:2], 2'b00};
            membe_d    = lane_be;
            memwdata_d = lane_wdata;
            state_d    = StWait;
          end
        end
      end
      StWait: begin
        if (MemAck) begin
          memreq_d = 1'b0;
          valid_d  = 1'b1;
          wdata_d  = memwe_q ? 32'd0 : ld_data;
          state_d  = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= StIdle;
      op_q       <= 6'd0;
      off_q      <= 2'd0;
      memreq_q   <= 1'b0;
      memwe_q    <= 1'b0;
      memaddr_q  <= 32'd0;
      membe_q    <= 4'd0;
      memwdata_q <= 32'd0;
      valid_q    <= 1'b0;
      wdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      off_q      <= off_d;
      memreq_q   <= memreq_d;
      memwe_q    <= memwe_d;
      memaddr_q  <= memaddr_d;
      membe_q    <= membe_d;
      memwdata_q <= memwdata_d;
      valid_q    <= valid_d;
      wdata_q    <= wdata_d;
    end
  end

`ifdef MEM_ALIGN_EXC_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      exc_q <= 1'b0;
    end else begin
      exc_q <= exc_d;
    end
  end
  assign Exc = exc_q;
`else
  assign Exc = 1'b0;
`endif

  // Reset gates Stall so upstream is released the instant RST falls.
  assign Stall = RST & (((state_q == StIdle) & InValid & is_memop & ~misaligned)
                      | ((state_q == StWait) & ~MemAck));

  assign MemReq   = memreq_q;
  assign MemWe    = memwe_q;
  assign MemAddr  = memaddr_q;
  assign MemBe    = membe_q;
  assign MemWdata = memwdata_q;
  assign Valid    = valid_q;
  assign Wdata    = wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed vectors push expected write-back values, a monitor
// pops and compares on every Valid pulse.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] ins = 32'd0;
  logic [31:0] result = 32'd0;
  logic [31:0] rdata2 = 32'd0;
  logic        stall, mem_req, mem_we, valid, exc;
  logic [31:0] mem_addr, mem_wdata, wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [32:0] exp_q[$];
  int          vcyc_q[$];

  mem_stage dut (
    .CLK      (clk),
    .RST      (rst),
    .InValid  (in_valid),
    .Ins      (ins),
    .Result   (result),
    .Rdata2   (rdata2),
    .Stall    (stall),
    .MemReq   (mem_req),
    .MemWe    (mem_we),
    .MemAddr  (mem_addr),
    .MemBe    (mem_be),
    .MemWdata (mem_wdata),
    .MemAck   (mem_ack),
    .MemRdata (mem_rdata),
    .Valid    (valid),
    .Wdata    (wdata),
    .Exc      (exc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every Valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && valid) begin
      vcyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("wdata", wdata, e[31:0]);
        chk("exc", {31'd0, exc}, {31'd0, e[32]});
      end
    end
  end

  // Presents one pass-through op at the current negedge and advances to the next negedge.
  task automatic passthru(input logic [5:0] op, input logic [31:0] res);
    in_valid = 1'b1;
    ins      = {op, 26'h0};
    result   = res;
    #1 chk("pt_stall", {31'd0, stall}, 32'd0);
    exp_q.push_back({1'b0, res});
    @(negedge clk);
  endtask

  task automatic mem_op(input logic [5:0] op, input logic [31:0] res, input logic [31:0] rd2,
                        input int waits, input logic [31:0] rdata, input logic [31:0] eaddr,
                        input logic [3:0] ebe, input logic ewe, input logic [31:0] ewdata,
                        input logic [31:0] ewb);
    in_valid = 1'b1;
    ins      = {op, 26'h0};
    result   = res;
    rdata2   = rd2;
    #1 chk("accept_stall", {31'd0, stall}, 32'd1);
    exp_q.push_back({1'b0, ewb});
    @(negedge clk);
    chk("memreq", {31'd0, mem_req}, 32'd1);
    chk("memaddr", mem_addr, eaddr);
    chk("membe", {28'd0, mem_be}, {28'd0, ebe});
    chk("memwe", {31'd0, mem_we}, {31'd0, ewe});
    if (ewe) chk("memwdata", mem_wdata, ewdata);
    for (int i = 0; i < waits; i++) begin
      chk("wait_stall", {31'd0, stall & mem_req}, 32'd1);
      @(negedge clk);
    end
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    #1 chk("ack_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    mem_ack  = 1'b0;
    in_valid = 1'b0;
    chk("req_drop", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_memreq", {31'd0, mem_req}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_outs", mem_addr | mem_wdata | wdata | {28'd0, mem_be}, 32'd0);
    chk("rst_flags", {29'd0, mem_we, exc, stall}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Pass-through, then three back-to-back.
    passthru(6'h00, 32'h0000_1234);
    in_valid = 1'b0;
    @(negedge clk);
    passthru(6'h00, 32'h1111_0001);
    passthru(6'h0F, 32'h2222_0002);
    passthru(6'h08, 32'h3333_0003);
    in_valid = 1'b0;
    mem_ack  = 1'b1;  // ack outside WAIT must be ignored
    @(negedge clk);
    mem_ack  = 1'b0;
    chk("stray_ack_req", {31'd0, mem_req}, 32'd0);

    // Loads: byte/half extension and lane selection.
    mem_op(6'h20, 32'h103, 32'd0, 3, 32'h80FF_FFFF, 32'h100, 4'hF, 1'b0, 32'd0, 32'hFFFF_FF80);
    mem_op(6'h24, 32'h103, 32'd0, 3, 32'h80FF_FFFF, 32'h100, 4'hF, 1'b0, 32'd0, 32'h0000_0080);
    mem_op(6'h20, 32'h100, 32'd0, 0, 32'h0000_007F, 32'h100, 4'hF, 1'b0, 32'd0, 32'h0000_007F);
    mem_op(6'h21, 32'h102, 32'd0, 1, 32'h8001_7FFF, 32'h100, 4'hF, 1'b0, 32'd0, 32'hFFFF_8001);
    mem_op(6'h25, 32'h102, 32'd0, 1, 32'h8001_7FFF, 32'h100, 4'hF, 1'b0, 32'd0, 32'h0000_8001);
    mem_op(6'h23, 32'h010, 32'd0, 2, 32'hCAFE_F00D, 32'h010, 4'hF, 1'b0, 32'd0, 32'hCAFE_F00D);

    // Stores: lane steering, write-back value 0.
    mem_op(6'h29, 32'h202, 32'hAAAA_BEEF, 1, 32'hDEAD_BEEF, 32'h200, 4'b1100, 1'b1,
           32'hBEEF_BEEF, 32'd0);
    mem_op(6'h28, 32'h301, 32'h1234_5678, 0, 32'hDEAD_BEEF, 32'h300, 4'b0010, 1'b1,
           32'h7878_7878, 32'd0);
    mem_op(6'h2B, 32'h400, 32'h0BAD_F00D, 2, 32'hDEAD_BEEF, 32'h400, 4'b1111, 1'b1,
           32'h0BAD_F00D, 32'd0);

    // Misaligned word load.
`ifdef MEM_ALIGN_EXC_EN
    in_valid = 1'b1;
    ins      = {6'h23, 26'h0};
    result   = 32'h6;
    #1 chk("misal_stall", {31'd0, stall}, 32'd0);
    exp_q.push_back({1'b1, 32'h6});
    @(negedge clk);
    in_valid = 1'b0;
    chk("misal_noreq", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
`else
    mem_op(6'h23, 32'h006, 32'd0, 1, 32'h5566_7788, 32'h004, 4'hF, 1'b0, 32'd0, 32'h5566_7788);
`endif

    // Reset while WAIT with MemReq high.
    in_valid = 1'b1;
    ins      = {6'h23, 26'h0};
    result   = 32'h40;
    exp_q.push_back({1'b0, 32'hFFFF_FFFF});
    @(negedge clk);
    chk("pre_rst_req", {31'd0, mem_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst_req_drop", {31'd0, mem_req}, 32'd0);
    chk("rst_stall_drop", {31'd0, stall}, 32'd0);
    chk("rst_valid_drop", {31'd0, valid}, 32'd0);
    exp_q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mem_op(6'h23, 32'h044, 32'd0, 0, 32'h0F0F_0F0F, 32'h044, 4'hF, 1'b0, 32'd0, 32'h0F0F_0F0F);

    // LW acked on first request cycle, then ADD held until accepted in IDLE after DONE.
    vcyc_q.delete();
    in_valid = 1'b1;
    ins      = {6'h23, 26'h0};
    result   = 32'h80;
    exp_q.push_back({1'b0, 32'h1357_9BDF});
    @(negedge clk);
    chk("b2b_req", {31'd0, mem_req}, 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = 32'h1357_9BDF;
    @(negedge clk);
    mem_ack = 1'b0;
    ins     = {6'h00, 26'h20};
    result  = 32'h0000_00AD;
    exp_q.push_back({1'b0, 32'h0000_00AD});
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b_count", vcyc_q.size(), 32'd2);
    if (vcyc_q.size() == 2) chk("b2b_gap", vcyc_q[1] - vcyc_q[0], 32'd2);

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
